// File: rtl/am_channel_sequencer.sv
// rtl/am_channel_sequencer.sv - channel-enable scheduler for the AM NCO bank (STATIC/WALK/RAMP/MASKED_WALK)
// Optional all-off guard interval between patterns: define AM_SEQ_GUARD_GAP_EN.
module am_channel_sequencer #(
    parameter int NUM_CH       = 12,
    parameter int IDX_W        = 4,
    parameter int GUARD_CYCLES = 1250
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              master_enable,
    input  logic              watchdog_triggered,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [1:0]        seq_mode,
    input  logic [31:0]       dwell_cycles,
    input  logic              start,
    input  logic              stop,
    output logic [NUM_CH-1:0] ch_enable_out,
    output logic              seq_busy,
    output logic [IDX_W-1:0]  step_index,
    output logic              step_strobe,
    output logic              cycle_done,
    output logic              seq_error
);

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_RAMP   = 2'd2;
    localparam logic [1:0] MODE_MWALK  = 2'd3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    generate
        if ((2 ** IDX_W) < NUM_CH || GUARD_CYCLES < 1) begin : g_param_check
            $error("am_channel_sequencer: IDX_W too small for NUM_CH or GUARD_CYCLES < 1");
        end
    endgenerate

`ifdef AM_SEQ_GUARD_GAP_EN
    localparam logic [31:0] GUARD_LOAD = 32'(GUARD_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GUARD
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [31:0]         dwell_q, dwell_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [NUM_CH-1:0]   en_q, en_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                strobe_q, strobe_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                abort;
    logic                advance;
    logic                go_idle;
    logic [31:0]         dwell_eff;
    logic [IDX_W-1:0]    first_idx;
    logic [IDX_W-1:0]    nxt_idx;
    logic                nxt_wrap;

    function automatic logic [NUM_CH-1:0] pattern(input logic [1:0] mode, input logic [IDX_W-1:0] k);
        logic [NUM_CH-1:0] onehot;
        onehot = NUM_CH'(1) << k;
        // Thermometer code: the one-hot bit plus everything below it.
        return (mode == MODE_RAMP) ? (onehot | (onehot - NUM_CH'(1))) : onehot;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] next_set(input logic [NUM_CH-1:0] m, input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] r;
        logic             found;
        int               j;
        r     = k;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            j = (int'(k) + i) % NUM_CH;
            if (!found && m[j]) begin
                r     = IDX_W'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign abort     = stop | ~master_enable | watchdog_triggered;
    assign dwell_eff = (dwell_cycles == 32'd0) ? 32'd1 : dwell_cycles;
    assign first_idx = (seq_mode == MODE_MWALK) ? lowest_set(ch_mask) : '0;

    // Masked walk wraps when the circular search lands at or below the current bit,
    // which also covers a single-bit mask revisiting itself.
    always_comb begin
        nxt_idx  = idx_q + IDX_W'(1);
        nxt_wrap = (idx_q == LAST_IDX);
        if (mode_q == MODE_MWALK) begin
            nxt_idx  = next_set(mask_q, idx_q);
            nxt_wrap = (nxt_idx <= idx_q);
        end else if (nxt_wrap) begin
            nxt_idx = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        busy_d   = busy_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        advance  = 1'b0;
        go_idle  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                idx_d  = '0;
                en_d   = (master_enable && !watchdog_triggered) ? ch_mask : '0;
                if (start && !abort && seq_mode != MODE_STATIC) begin
                    if (seq_mode == MODE_MWALK && ch_mask == '0) begin
                        err_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        mode_d   = seq_mode;
                        mask_d   = ch_mask;
                        dwell_d  = dwell_eff;
                        cnt_d    = dwell_eff - 32'd1;
                        idx_d    = first_idx;
                        en_d     = pattern(seq_mode, first_idx);
                        strobe_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    go_idle = 1'b1;
                end else if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
`ifdef AM_SEQ_GUARD_GAP_EN
                    state_d = S_GUARD;
                    en_d    = '0;
                    cnt_d   = GUARD_LOAD;
`else
                    advance = 1'b1;
`endif
                end
            end
`ifdef AM_SEQ_GUARD_GAP_EN
            S_GUARD: begin
                if (abort) begin
                    go_idle = 1'b1;
                end else if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    advance = 1'b1;
                    state_d = S_RUN;
                end
            end
`endif
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (advance) begin
            idx_d    = nxt_idx;
            en_d     = pattern(mode_q, nxt_idx);
            strobe_d = 1'b1;
            done_d   = nxt_wrap;
            cnt_d    = dwell_q - 32'd1;
        end

        if (go_idle) begin
            state_d = S_IDLE;
            en_d    = '0;
            busy_d  = 1'b0;
            idx_d   = '0;
            cnt_d   = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'd0;
            mask_q   <= '0;
            dwell_q  <= 32'd0;
            cnt_q    <= 32'd0;
            en_q     <= '0;
            busy_q   <= 1'b0;
            idx_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ch_enable_out = en_q;
    assign seq_busy      = busy_q;
    assign step_index    = idx_q;
    assign step_strobe   = strobe_q;
    assign cycle_done    = done_q;
    assign seq_error     = err_q;

endmodule
